// File: rtl/game_io_pkg.sv
// rtl/game_io_pkg.sv - register map and bus width constants for the game I/O hub
package game_io_pkg;

    localparam int DATA_W = 32;

    localparam logic [2:0] ADDR_LED       = 3'd0;
    localparam logic [2:0] ADDR_HEX       = 3'd1;
    localparam logic [2:0] ADDR_KEYCODE   = 3'd2;
    localparam logic [2:0] ADDR_KEY_DATA  = 3'd3;
    localparam logic [2:0] ADDR_IRQ_MASK  = 3'd4;
    localparam logic [2:0] ADDR_EDGE_CAP  = 3'd5;
    localparam logic [2:0] ADDR_EDGE_MODE = 3'd6;

endpackage

// File: rtl/key_debounce.sv
// rtl/key_debounce.sv - one push-button: two-flop synchronizer plus saturating-free debounce counter
module key_debounce #(
    parameter int DEBOUNCE_CYC = 250000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_raw,
    output logic key_deb
);

    localparam int CW = $clog2(DEBOUNCE_CYC + 1);
    localparam logic [CW-1:0] LIMIT = CW'(DEBOUNCE_CYC);

    logic          sync_1;
    logic          sync_2;
    logic [CW-1:0] cnt;

    // Released buttons read high, so resetting to ones avoids a spurious edge on release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_1  <= 1'b1;
            sync_2  <= 1'b1;
            key_deb <= 1'b1;
            cnt     <= '0;
        end else begin
            sync_1 <= key_raw;
            sync_2 <= sync_1;
            if (sync_2 == key_deb) begin
                cnt <= '0;
            end else if (cnt == LIMIT - 1'b1) begin
                key_deb <= ~key_deb;
                cnt     <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/game_io_hub.sv
// rtl/game_io_hub.sv - register-mapped LED/hex/keycode outputs with debounced, interrupting keys
module game_io_hub
    import game_io_pkg::*;
#(
    parameter int NUM_KEYS     = 2,
    parameter int LED_W        = 14,
    parameter int HEX_W        = 16,
    parameter int KC_CH        = 4,
    parameter int KC_W         = 8,
    parameter int DEBOUNCE_CYC = 250000
) (
    input  logic                  clk_clk,
    input  logic                  reset_reset_n,
    input  logic [2:0]            avs_address,
    input  logic                  avs_read,
    input  logic                  avs_write,
    input  logic [DATA_W-1:0]     avs_writedata,
    output logic [DATA_W-1:0]     avs_readdata,
    output logic                  irq,
    input  logic [NUM_KEYS-1:0]   key_export,
    output logic [LED_W-1:0]      leds_export,
    output logic [HEX_W-1:0]      hex_digits_export,
    output logic [KC_CH*KC_W-1:0] keycode_export
);

    localparam int KC_TW = KC_CH * KC_W;

    logic [LED_W-1:0]    led_q;
    logic [HEX_W-1:0]    hex_q;
    logic [KC_TW-1:0]    kc_q;
    logic [NUM_KEYS-1:0] mask_q;
    logic [NUM_KEYS-1:0] cap_q;
    logic [NUM_KEYS-1:0] mode_q;
    logic [NUM_KEYS-1:0] deb;
    logic [NUM_KEYS-1:0] deb_prev;
    logic [NUM_KEYS-1:0] edge_set;
    logic [NUM_KEYS-1:0] cap_clr;
    logic [DATA_W-1:0]   rd_mux;

    for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
        key_debounce #(
            .DEBOUNCE_CYC(DEBOUNCE_CYC)
        ) u_key_debounce (
            .clk    (clk_clk),
            .rst_n  (reset_reset_n),
            .key_raw(key_export[k]),
            .key_deb(deb[k])
        );
    end

    // Mode bit 1 selects rising transitions, 0 falling; mode alone never fires.
    always_comb begin
        edge_set = (deb ^ deb_prev) & ~(deb ^ mode_q);
        cap_clr  = '0;
        if (avs_write && avs_address == ADDR_EDGE_CAP) begin
            cap_clr = avs_writedata[NUM_KEYS-1:0];
        end
    end

    always_comb begin
        rd_mux = '0;
        case (avs_address)
            ADDR_LED:       rd_mux = DATA_W'(led_q);
            ADDR_HEX:       rd_mux = DATA_W'(hex_q);
            ADDR_KEYCODE:   rd_mux = DATA_W'(kc_q);
            ADDR_KEY_DATA:  rd_mux = DATA_W'(deb);
            ADDR_IRQ_MASK:  rd_mux = DATA_W'(mask_q);
            ADDR_EDGE_CAP:  rd_mux = DATA_W'(cap_q);
            ADDR_EDGE_MODE: rd_mux = DATA_W'(mode_q);
            default:        rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            led_q        <= '0;
            hex_q        <= '0;
            kc_q         <= '0;
            mask_q       <= '0;
            cap_q        <= '0;
            mode_q       <= '0;
            deb_prev     <= '1;
            irq          <= 1'b0;
            avs_readdata <= '0;
        end else begin
            if (avs_write) begin
                case (avs_address)
                    ADDR_LED:       led_q  <= avs_writedata[LED_W-1:0];
                    ADDR_HEX:       hex_q  <= avs_writedata[HEX_W-1:0];
                    ADDR_KEYCODE:   kc_q   <= avs_writedata[KC_TW-1:0];
                    ADDR_IRQ_MASK:  mask_q <= avs_writedata[NUM_KEYS-1:0];
                    ADDR_EDGE_MODE: mode_q <= avs_writedata[NUM_KEYS-1:0];
                    default: ;
                endcase
            end
            // A capture in the same cycle as its clear wins.
            cap_q    <= (cap_q & ~cap_clr) | edge_set;
            deb_prev <= deb;
            irq      <= |(cap_q & mask_q);
            if (avs_read) begin
                avs_readdata <= rd_mux;
            end
        end
    end

    assign leds_export       = led_q;
    assign hex_digits_export = hex_q;
    assign keycode_export    = kc_q;

endmodule
